// File: rtl/mul_share_arbiter_if.sv
// rtl/mul_share_arbiter_if.sv - request, response and shared-multiplier signals of mul_share_arbiter
interface mul_share_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 8
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*W-1:0]     req_a;
  logic [N_REQ*W-1:0]     req_b;
  logic [N_REQ-1:0]       rsp_valid;
  logic [N_REQ-1:0]       rsp_ready;
  logic [N_REQ*2*W-1:0]   rsp_product;
  logic [W-1:0]           mul_a;
  logic [W-1:0]           mul_b;
  logic [2*W-1:0]         mul_product;
  logic                   busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready, mul_product,
    input  req_ready, rsp_valid, rsp_product, mul_a, mul_b, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mul_product,
    output req_ready, rsp_valid, rsp_product, mul_a, mul_b, busy
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin sharing of one pipelined multiplier among N_REQ requesters
module mul_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W       = 8,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  mul_share_arbiter_if.slave bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW = 2 * W;

  logic [IW-1:0]        ptr;
  logic [N_REQ-1:0]     pending;
  logic [N_REQ-1:0]     rsp_valid_q;
  logic [N_REQ*PW-1:0]  rsp_product_q;
  logic [MUL_LAT-1:0]   tag_v;
  logic [IW-1:0]        tag_idx [MUL_LAT];

  logic [N_REQ-1:0]     eligible;
  logic                 grant_any;
  logic [IW-1:0]        grant_idx;
  logic [IW:0]          scan_sum;
  logic [IW-1:0]        cand;

  assign eligible = bus.req_valid & ~pending & ~rsp_valid_q;

  // Scan from ptr upwards with wrap; first eligible index wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_sum  = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_sum = {1'b0, ptr} + (IW+1)'(k);
      if (scan_sum >= (IW+1)'(N_REQ)) begin
        scan_sum = scan_sum - (IW+1)'(N_REQ);
      end
      cand = scan_sum[IW-1:0];
      if (!grant_any && eligible[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    bus.mul_a     = '0;
    bus.mul_b     = '0;
    if (grant_any && !rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant_idx == IW'(i)) begin
          bus.req_ready[i] = 1'b1;
          bus.mul_a        = bus.req_a[i*W +: W];
          bus.mul_b        = bus.req_b[i*W +: W];
        end
      end
    end
  end

  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_product = rsp_product_q;
  assign bus.busy        = (|pending) | (|rsp_valid_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr           <= '0;
      pending       <= '0;
      rsp_valid_q   <= '0;
      rsp_product_q <= '0;
      tag_v         <= '0;
      for (int s = 0; s < MUL_LAT; s++) begin
        tag_idx[s] <= '0;
      end
    end else begin
      if (grant_any) begin
        ptr                <= (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + IW'(1);
        pending[grant_idx] <= 1'b1;
      end

      // Tags travel alongside the operands so each product finds its owner.
      tag_v[0]   <= grant_any;
      tag_idx[0] <= grant_idx;
      for (int s = 1; s < MUL_LAT; s++) begin
        tag_v[s]   <= tag_v[s-1];
        tag_idx[s] <= tag_idx[s-1];
      end

      rsp_valid_q <= rsp_valid_q & ~bus.rsp_ready;
      for (int i = 0; i < N_REQ; i++) begin
        if (tag_v[MUL_LAT-1] && tag_idx[MUL_LAT-1] == IW'(i)) begin
          rsp_valid_q[i]              <= 1'b1;
          pending[i]                  <= 1'b0;
          rsp_product_q[i*PW +: PW]   <= bus.mul_product;
        end
      end
    end
  end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - scoreboard bench for mul_share_arbiter with a two-stage multiplier model
module tb_mul_share_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int PW = 16;
  localparam int RSP_LAT = 3;

  typedef struct {
    int              idx;
    logic [PW-1:0]   prod;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_share_arbiter_if #(.N_REQ(N), .W(W)) bus ();

  mul_share_arbiter #(.N_REQ(N), .W(W), .MUL_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Shared multiplier: operands registered, then product registered; no reset on purpose.
  logic [W-1:0] ma_q, mb_q;
  always_ff @(posedge clk) begin
    ma_q            <= bus.mul_a;
    mb_q            <= bus.mul_b;
    bus.mul_product <= PW'(ma_q) * PW'(mb_q);
  end

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb[$];
  int   gcyc [N];
  int   acyc [N];
  int   ptr_m;
  logic [N-1:0] hs;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] cyc=%0d actual=%h expected=%h", name, i, cyc, act, exp);
    end
  endtask

  // Request side: reference round-robin choice, pushes expected products.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        ptr_m = 0;
        for (int i = 0; i < N; i++) gcyc[i] = -1;
        sb.delete();
        chk("rst_req_ready", 0, 32'(bus.req_ready), 0);
        chk("rst_mul_a", 0, 32'(bus.mul_a), 0);
        chk("rst_mul_b", 0, 32'(bus.mul_b), 0);
      end else begin
        int            g;
        logic [N-1:0]  er;
        logic [W-1:0]  ea, eb;
        g = -1;
        for (int k = 0; k < N; k++) begin
          int  j;
          bit  live;
          j    = (ptr_m + k) % N;
          live = (gcyc[j] > acyc[j]) || (acyc[j] == cyc);
          if (g < 0 && bus.req_valid[j] && !live) g = j;
        end
        er = '0;
        ea = '0;
        eb = '0;
        if (g >= 0) begin
          er[g] = 1'b1;
          ea    = bus.req_a[g*W +: W];
          eb    = bus.req_b[g*W +: W];
        end
        chk("req_ready", g, 32'(bus.req_ready), 32'(er));
        chk("mul_a", g, 32'(bus.mul_a), 32'(ea));
        chk("mul_b", g, 32'(bus.mul_b), 32'(eb));
        if (g >= 0) begin
          sb.push_back('{idx: g, prod: PW'(ea) * PW'(eb)});
          gcyc[g] = cyc;
          ptr_m   = (g + 1) % N;
        end
      end
    end
  end

  // Response side: timing, product and busy checks; pops on accept.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < N; i++) begin
          acyc[i] = -1;
          chk("rst_rsp_product", i, 32'(bus.rsp_product[i*PW +: PW]), 0);
        end
        chk("rst_rsp_valid", 0, 32'(bus.rsp_valid), 0);
        chk("rst_busy", 0, 32'(bus.busy), 0);
      end else begin
        bit bz;
        bz = 1'b0;
        for (int i = 0; i < N; i++) begin
          bit live, ev;
          live = (gcyc[i] > acyc[i]) && (gcyc[i] < cyc);
          ev   = live && (cyc >= gcyc[i] + RSP_LAT);
          bz   = bz | live;
          chk("rsp_valid", i, 32'(bus.rsp_valid[i]), 32'(ev));
          if (ev) begin
            int fe;
            fe = -1;
            for (int e = 0; e < sb.size(); e++) begin
              if (fe < 0 && sb[e].idx == i) fe = e;
            end
            chk("sb_entry", i, 32'(fe >= 0), 1);
            if (fe >= 0) begin
              chk("rsp_product", i, 32'(bus.rsp_product[i*PW +: PW]), 32'(sb[fe].prod));
              if (bus.rsp_ready[i]) begin
                sb.delete(fe);
                acyc[i] = cyc;
              end
            end
          end
        end
        chk("busy", 0, 32'(bus.busy), 32'(bz));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    hs = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~hs;
  endtask

  task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_valid[i]       = 1'b1;
    bus.req_a[i*W +: W]    = a;
    bus.req_b[i*W +: W]    = b;
  endtask

  task automatic do_reset(input int n);
    bus.req_valid = '0;
    rst = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '1;
    do_reset(3);

    issue(1, 8'hFF, 8'hFF);
    repeat (6) step();

    do_reset(1);
    for (int i = 0; i < N; i++) issue(i, 8'((i + 1) * 16), 8'(i + 1));
    repeat (8) step();

    do_reset(1);
    issue(2, 8'h05, 8'h07);
    step();
    issue(0, 8'h03, 8'h09);
    issue(3, 8'h0B, 8'h0D);
    repeat (6) step();

    bus.rsp_ready[0] = 1'b0;
    issue(0, 8'h80, 8'h02);
    step();
    for (int c = 0; c < 8; c++) begin
      if (!bus.req_valid[0]) issue(0, 8'h11, 8'h22);
      if (!bus.req_valid[1]) issue(1, 8'($urandom), 8'($urandom));
      if (!bus.req_valid[3]) issue(3, 8'($urandom), 8'($urandom));
      step();
    end
    bus.rsp_ready = '1;
    repeat (8) step();

    do_reset(1);
    issue(2, 8'h12, 8'h34);
    step();
    do_reset(1);
    issue(2, 8'h00, 8'hAB);
    repeat (6) step();

    repeat (400) begin
      bus.rsp_ready = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i] && $urandom_range(0, 1) == 1) issue(i, 8'($urandom), 8'($urandom));
      end
      step();
    end

    bus.rsp_ready = '1;
    repeat (10) step();
    chk("sb_drained", 0, 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
